// File: rtl/sipo8_loader.sv
// -----------------------------------------------------------------------------
// sipo8_loader
//
// Serial-in / parallel-out front end for a downstream 8-bit register.
// Collects DATA_W serial bits into a word and shows the word on byte_out.
// It then raises load_en for one cycle so that the downstream register captures
// exactly one complete word per frame. Partial words are never visible, because
// byte_out comes from a separate holding register that is updated only when a
// frame completes.
//
// Parameters
//   DATA_W     word width in bits (2..32)
//   MSB_FIRST  1: first serial bit ends up in byte_out[DATA_W-1]
//              0: first serial bit ends up in byte_out[0]
//
// Ports
//   Clk        system clock, rising edge
//   Res        asynchronous active-low reset
//   start      begin a frame (taken in IDLE and LOAD)
//   abort      cancel the current frame (taken in SHIFT)
//   ser_in     serial data bit
//   ser_valid  ser_in is valid this cycle
//   byte_out   last completed word, stable between loads
//   load_en    one-cycle enable strobe for the downstream register
//   busy       high while a frame is being shifted in
//   bit_cnt    bits received so far in the current frame
//   ovr        sticky overrun flag (bit offered while in LOAD)
// -----------------------------------------------------------------------------
module sipo8_loader #(
  parameter int  DATA_W    = 8,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = $clog2(DATA_W)
) (
  input  logic              Clk,
  input  logic              Res,
  input  logic              start,
  input  logic              abort,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [DATA_W-1:0] byte_out,
  output logic              load_en,
  output logic              busy,
  output logic [CW-1:0]     bit_cnt,
  output logic              ovr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_sreg;
  logic [DATA_W-1:0] r_byte;
  logic [CW-1:0]     r_cnt;
  logic              r_ovr;

  logic [DATA_W-1:0] w_shifted;
  logic              w_last_bit;

  // Next shift-register value, including the bit on ser_in this cycle. The
  // completed word is taken from here rather than from r_sreg, so that the
  // last bit is already part of the word when it is loaded.
  // NOTE: every signal assigned in always_comb receives a value on every path,
  // so no latch is inferred.
  always_comb begin
    w_shifted = r_sreg;
    if (MSB_FIRST) begin
      w_shifted = {r_sreg[DATA_W-2:0], ser_in};
    end else begin
      w_shifted = {ser_in, r_sreg[DATA_W-1:1]};
    end
  end

  assign w_last_bit = (r_cnt == CW'(DATA_W - 1));

  // NOTE: sequential state uses only non-blocking assignments, so every
  // register in this block reads the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Res) begin
    if (!Res) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_byte  <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SHIFT;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
          end
        end

        ST_SHIFT: begin
          // abort wins even when this cycle carries the last bit.
          if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (ser_valid) begin
            r_sreg <= w_shifted;
            if (w_last_bit) begin
              r_byte  <= w_shifted;
              r_cnt   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        ST_LOAD: begin
          // No shifting happens in LOAD. An offered bit is dropped and flagged.
          // Clearing ovr is done only from IDLE, so a set here always holds.
          if (ser_valid) begin
            r_ovr <= 1'b1;
          end
          if (start) begin
            r_state <= ST_SHIFT;
            r_sreg  <= '0;
            r_cnt   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // The fourth encoding is never entered, but it recovers to IDLE.
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // busy and load_en are decoded straight from the asynchronously reset state
  // register, so they fall as soon as Res is asserted.
  assign busy     = (r_state == ST_SHIFT);
  assign load_en  = (r_state == ST_LOAD);
  assign byte_out = r_byte;
  assign bit_cnt  = r_cnt;
  assign ovr      = r_ovr;

endmodule
